// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
// Configurable UART transmitter fed by a show-ahead FIFO. Data length, parity and
// stop-bit count are captured per frame on the pop cycle.
module uart_tx_cfg #(
    parameter int unsigned MAX_DATA    = 8,
    parameter int unsigned OVER_SAMPLE = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stick,
    input  logic                i_tx_en,
    input  logic                i_fifo_empty,
    input  logic [MAX_DATA-1:0] i_tx_data,
    input  logic [4:0]          i_data_len,
    input  logic [1:0]          i_parity_mode,
    input  logic                i_stop2,
    output logic                o_fifo_rd,
    output logic                o_tx_serial,
    output logic                o_tx_busy,
    output logic                o_tx_done
);
    localparam int unsigned   CW        = $clog2(OVER_SAMPLE);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVER_SAMPLE - 1);
    localparam logic [4:0]    MIN_LEN   = 5'd5;
    localparam logic [4:0]    MAX_LEN   = 5'(MAX_DATA);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       tick_cnt;
    logic [4:0]          bit_idx;
    logic [4:0]          idx_next;
    logic [MAX_DATA-1:0] data_q;
    logic [MAX_DATA-1:0] data_mask;
    logic [MAX_DATA-1:0] bit_sel;
    logic [4:0]          len_q;
    logic [4:0]          len_eff;
    logic [1:0]          pmode_q;
    logic                stop2_q;
    logic                armed;
    logic                accept;
    logic                bit_end;
    logic                frame_end;
    logic                finish_q;
    logic                par_en;
    logic                par_bit;
    logic                serial_next;

    always_comb begin
        len_eff = i_data_len;
        if (i_data_len < MIN_LEN) begin
            len_eff = MIN_LEN;
        end else if (i_data_len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
    end

    // armed keeps the pop strobe low until the first clock edge after reset release
    assign accept    = armed & (state == IDLE) & i_tx_en & ~i_fifo_empty;
    assign o_fifo_rd = accept;
    assign bit_end   = (state != IDLE) & i_stick & (tick_cnt == TICK_LAST);

    assign data_mask = ~({MAX_DATA{1'b1}} << len_q);
    assign bit_sel   = {{(MAX_DATA-1){1'b0}}, 1'b1} << bit_idx;
    assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign par_bit   = (^(data_q & data_mask)) ^ pmode_q[1];

    always_comb begin
        state_next = state;
        idx_next   = bit_idx;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    idx_next   = '0;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == len_q - 5'd1) begin
                        idx_next   = '0;
                        state_next = par_en ? PARITY : STOP;
                    end else begin
                        idx_next = bit_idx + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                // bit_idx doubles as the stop-bit counter
                if (bit_end) begin
                    if (stop2_q && (bit_idx == '0)) begin
                        idx_next = 5'd1;
                    end else begin
                        idx_next   = '0;
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        serial_next = 1'b1;
        case (state)
            START:   serial_next = 1'b0;
            DATA:    serial_next = |(data_q & bit_sel);
            PARITY:  serial_next = par_bit;
            default: serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            bit_idx     <= '0;
            tick_cnt    <= '0;
            data_q      <= '0;
            len_q       <= MIN_LEN;
            pmode_q     <= '0;
            stop2_q     <= 1'b0;
            armed       <= 1'b0;
            finish_q    <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_busy   <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            state   <= state_next;
            bit_idx <= idx_next;
            armed   <= 1'b1;
            if ((state == IDLE) || (state_next == IDLE)) begin
                tick_cnt <= '0;
            end else if (i_stick) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            end
            if (accept) begin
                data_q  <= i_tx_data;
                len_q   <= len_eff;
                pmode_q <= i_parity_mode;
                stop2_q <= i_stop2;
            end
            o_tx_serial <= serial_next;
            o_tx_busy   <= state inside {START, DATA, PARITY, STOP};
            finish_q    <= frame_end;
            o_tx_done   <= finish_q;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_cfg: table of single frames plus hand-written
// back-to-back and mid-frame reset sequences.
module tb_uart_tx_cfg;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       stick;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] tx_data;
    logic [4:0] data_len;
    logic [1:0] pmode;
    logic       stop2;
    logic       fifo_rd;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int tests = 0;
    int fails = 0;

    uart_tx_cfg #(.MAX_DATA(8), .OVER_SAMPLE(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stick       (stick),
        .i_tx_en       (tx_en),
        .i_fifo_empty  (fifo_empty),
        .i_tx_data     (tx_data),
        .i_data_len    (data_len),
        .i_parity_mode (pmode),
        .i_stop2       (stop2),
        .o_fifo_rd     (fifo_rd),
        .o_tx_serial   (tx_serial),
        .o_tx_busy     (tx_busy),
        .o_tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [4:0]  len;
        logic [1:0]  pmode;
        logic        stop2;
        int unsigned div;
        int unsigned nbits;
        logic [19:0] seq;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sampling point m is 1ns after the m-th edge following the accept edge.
    task automatic run_vec(input vec_t v);
        int unsigned bp;
        int unsigned total;
        int unsigned b;
        int unsigned unstable;
        int unsigned done_at;
        int unsigned done_cnt;
        int unsigned busy_cnt;
        int unsigned rd_cnt;
        logic [19:0] act;
        logic [19:0] mask;
        bp    = 16 * v.div;
        total = v.nbits * bp;
        @(posedge clk); #1;
        tx_data    = v.data;
        data_len   = v.len;
        pmode      = v.pmode;
        stop2      = v.stop2;
        fifo_empty = 1'b0;
        tx_en      = 1'b1;
        stick      = 1'b1;
        #1;
        check({v.name, "_rd"}, fifo_rd, 1);
        act = '0; unstable = 0; done_at = 0; done_cnt = 0; busy_cnt = 0; rd_cnt = 0;
        for (int unsigned m = 0; m <= total + 3; m++) begin
            @(posedge clk); #1;
            if (m == 0) begin
                tx_data    = ~v.data;
                data_len   = v.len ^ 5'd6;
                pmode      = v.pmode ^ 2'b01;
                stop2      = ~v.stop2;
                fifo_empty = 1'b1;
                tx_en      = 1'b0;
            end
            stick = ((m + 1) % v.div) == 0;
            #1;
            if (fifo_rd) rd_cnt++;
            if (tx_busy) busy_cnt++;
            if (tx_done) begin
                done_cnt++;
                if (done_at == 0) done_at = m;
            end
            if (m >= 1 && m <= total) begin
                b = (m - 1) / bp;
                if ((m - 1) % bp == 0) act[b] = tx_serial;
                else if (tx_serial !== act[b]) unstable++;
            end
        end
        mask = (20'd1 << v.nbits) - 20'd1;
        check({v.name, "_bits"},     act & mask, v.seq);
        check({v.name, "_stable"},   unstable, 0);
        check({v.name, "_done_at"},  done_at, total + 1);
        check({v.name, "_done_cnt"}, done_cnt, 1);
        check({v.name, "_busy_len"}, busy_cnt, total);
        check({v.name, "_no_pop"},   rd_cnt, 0);
        stick = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        byte unsigned q[$];
        int           rd_cnt;
        int           done_cnt;
        int           rd_empty;
        int           last_rd;
        int           bad;
        logic         pending;

        vecs[0] = '{8'hA5, 5'd8,  2'b00, 1'b0, 1, 10, 20'b1101001010,  "8N1_A5"};
        vecs[1] = '{8'h83, 5'd7,  2'b01, 1'b1, 1, 11, 20'b11000000110, "7E2_83"};
        vecs[2] = '{8'h83, 5'd7,  2'b10, 1'b1, 1, 11, 20'b11100000110, "7O2_83"};
        vecs[3] = '{8'h3A, 5'd3,  2'b00, 1'b0, 1, 7,  20'b1110100,     "len3_clamp"};
        vecs[4] = '{8'h5C, 5'd20, 2'b00, 1'b0, 1, 10, 20'b1010111000,  "len20_clamp"};
        vecs[5] = '{8'hF7, 5'd6,  2'b01, 1'b0, 1, 9,  20'b111101110,   "6E1_F7"};
        vecs[6] = '{8'h1F, 5'd5,  2'b11, 1'b1, 1, 8,  20'b11111110,    "5N2_mode3"};
        vecs[7] = '{8'h96, 5'd8,  2'b00, 1'b0, 4, 10, 20'b1100101100,  "8N1_sparse"};

        rst_n = 1'b0; stick = 1'b1; tx_en = 1'b1; fifo_empty = 1'b0;
        tx_data = 8'hFF; data_len = 5'd8; pmode = 2'b00; stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial", tx_serial, 1);
        check("rst_busy",   tx_busy, 0);
        check("rst_done",   tx_done, 0);
        check("rst_rd",     fifo_rd, 0);
        rst_n = 1'b1;
        #1;
        check("rd_before_first_edge", fifo_rd, 0);
        tx_en = 1'b0;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Three queued words, enable held high: frames must abut with one idle cycle.
        q = '{8'h11, 8'h22, 8'h33};
        data_len = 5'd8; pmode = 2'b00; stop2 = 1'b0; stick = 1'b1; tx_en = 1'b1;
        pending = 1'b0; rd_cnt = 0; done_cnt = 0; rd_empty = 0; last_rd = -1;
        for (int c = 0; c < 530; c++) begin
            @(posedge clk); #1;
            if (pending && q.size() > 0) void'(q.pop_front());
            fifo_empty = (q.size() == 0);
            tx_data    = fifo_empty ? 8'h00 : q[0];
            #1;
            pending = fifo_rd;
            if (fifo_rd) begin
                rd_cnt++;
                if (fifo_empty) rd_empty++;
                if (last_rd >= 0) check("b2b_spacing", c - last_rd, 161);
                last_rd = c;
            end
            if (tx_done) done_cnt++;
        end
        check("b2b_pops",       rd_cnt, 3);
        check("b2b_dones",      done_cnt, 3);
        check("b2b_pop_empty",  rd_empty, 0);
        tx_en = 1'b0;
        repeat (2) @(posedge clk);

        // Reset asserted during data bit 3 of an 8N1 0xA5 frame (bit 3 is 0).
        @(posedge clk); #1;
        tx_data = 8'hA5; data_len = 5'd8; pmode = 2'b00; stop2 = 1'b0;
        fifo_empty = 1'b0; tx_en = 1'b1; stick = 1'b1;
        @(posedge clk); #1;
        fifo_empty = 1'b1;
        repeat (70) @(posedge clk);
        #3;
        check("pre_rst_serial", tx_serial, 0);
        check("pre_rst_busy",   tx_busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_serial", tx_serial, 1);
        check("midrst_busy",   tx_busy, 0);
        check("midrst_done",   tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (tx_serial !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
